// File: rtl/data_cache.sv
// data_cache: direct-mapped write-through write-allocate cache with one-word lines
module data_cache #(
  parameter int INDEX_WIDTH = 3,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cpu_ren,
  input  logic                 cpu_we,
  input  logic [31:0]          cpu_addr,
  input  logic [31:0]          cpu_din,
  output logic [31:0]          cpu_dout,
  output logic                 cpu_stall,
  output logic                 mem_ren,
  output logic                 mem_we,
  output logic                 mem_cs,
  output logic [31:0]          mem_addr,
  output logic [31:0]          mem_din,
  input  logic [31:0]          mem_dout,
  input  logic                 mem_ack,
  output logic [CNT_WIDTH-1:0] hit_cnt,
  output logic [CNT_WIDTH-1:0] miss_cnt
);
  localparam int LINES = 1 << INDEX_WIDTH;
  localparam int TW    = 32 - INDEX_WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_WRITE, S_DONE} state_t;

  state_t                 state, state_nx;
  logic [LINES-1:0]       valid;
  logic [TW-1:0]          tags [LINES];
  logic [31:0]            data [LINES];
  logic [INDEX_WIDTH-1:0] idx, fidx;
  logic                   hit, idle, fill_done;

  assign idx       = cpu_addr[INDEX_WIDTH-1:0];
  assign fidx      = mem_addr[INDEX_WIDTH-1:0];
  assign hit       = valid[idx] & (tags[idx] == cpu_addr[31:INDEX_WIDTH]);
  assign idle      = state == S_IDLE;
  assign fill_done = state == S_FILL && mem_ack;
  assign mem_cs    = mem_ren | mem_we;
  assign cpu_dout  = (hit && (idle || state == S_DONE)) ? data[idx] : '0;

  // State register; reset aborts any outstanding RAM request immediately
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= S_IDLE;
    else      state <= state_nx;

  // Next state and handshake/stall decode; stall is masked while in reset
  always_comb begin
    state_nx  = state;
    cpu_stall = 1'b0;
    mem_ren   = 1'b0;
    mem_we    = 1'b0;
    case (state)
      S_IDLE: begin
        cpu_stall = rst & (cpu_we | (cpu_ren & ~hit));
        state_nx  = cpu_we ? S_WRITE : (cpu_ren & ~hit) ? S_FILL : S_IDLE;
      end
      S_FILL: begin
        mem_ren   = 1'b1;
        cpu_stall = 1'b1;
        state_nx  = mem_ack ? S_DONE : S_FILL;
      end
      S_WRITE: begin
        mem_we    = 1'b1;
        cpu_stall = 1'b1;
        state_nx  = mem_ack ? S_DONE : S_WRITE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Valid bits, request capture and saturating hit/miss statistics
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      valid    <= '0;
      mem_addr <= '0;
      mem_din  <= '0;
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (idle) begin
      if (cpu_we) begin
        valid[idx] <= 1'b1;
        mem_addr   <= cpu_addr;
        mem_din    <= cpu_din;
      end else if (cpu_ren && !hit) begin
        mem_addr <= cpu_addr;
        miss_cnt <= miss_cnt + {{(CNT_WIDTH-1){1'b0}}, ~&miss_cnt};
      end else if (cpu_ren) begin
        hit_cnt <= hit_cnt + {{(CNT_WIDTH-1){1'b0}}, ~&hit_cnt};
      end
    end else if (fill_done) begin
      valid[fidx] <= 1'b1;
    end

  // Tag/data arrays are not reset; writes allocate at capture, fills land on ack
  always_ff @(posedge clk)
    if (rst && idle && cpu_we) begin
      data[idx] <= cpu_din;
      tags[idx] <= cpu_addr[31:INDEX_WIDTH];
    end else if (rst && fill_done) begin
      data[fidx] <= mem_dout;
      tags[fidx] <= mem_addr[31:INDEX_WIDTH];
    end
endmodule

// File: tb/tb_data_cache.sv
// tb_data_cache: directed table-driven bench with a fixed-latency RAM model
module tb_data_cache;
  localparam int CW  = 8;
  localparam int LAT = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cpu_ren = 1'b0, cpu_we = 1'b0;
  logic [31:0]   cpu_addr = '0, cpu_din = '0;
  logic [31:0]   cpu_dout, mem_addr, mem_din, mem_dout;
  logic          cpu_stall, mem_ren, mem_we, mem_cs;
  logic          mem_ack = 1'b0;
  logic [CW-1:0] hit_cnt, miss_cnt;

  logic [31:0]   ram [256];
  logic [255:0]  wrote = '0;
  int            ram_cnt = 0;
  int            total = 0, passed = 0;

  data_cache #(.INDEX_WIDTH(3), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst),
    .cpu_ren(cpu_ren), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
    .cpu_dout(cpu_dout), .cpu_stall(cpu_stall),
    .mem_ren(mem_ren), .mem_we(mem_we), .mem_cs(mem_cs),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout), .mem_ack(mem_ack),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  // Unwritten RAM words read back as C0DE0000 | address
  assign mem_dout = wrote[mem_addr[7:0]] ? ram[mem_addr[7:0]] : (32'hC0DE0000 | {24'h0, mem_addr[7:0]});

  // RAM: ack is high during the LAT-th cycle of a request, so a miss or write stalls 1+LAT cycles
  always @(posedge clk) begin
    if (mem_cs && !mem_ack) begin
      ram_cnt <= ram_cnt + 1;
      if (ram_cnt == LAT - 2) mem_ack <= 1'b1;
    end else begin
      ram_cnt <= 0;
      mem_ack <= 1'b0;
    end
    if (mem_we && mem_ack) begin
      ram[mem_addr[7:0]]   <= mem_din;
      wrote[mem_addr[7:0]] <= 1'b1;
    end
  end

  task automatic check(input string n, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", n, act, exp);
    else passed++;
  endtask

  task automatic req(input string n, input logic we, input logic ren, input logic [31:0] a,
                     input logic [31:0] d, input int exp_st, input logic [31:0] exp_do);
    int          st;
    logic [31:0] dout;
    @(negedge clk);
    cpu_we = we; cpu_ren = ren; cpu_addr = a; cpu_din = d;
    st = 0;
    #1;
    while (cpu_stall && st <= 100) begin
      st++;
      @(negedge clk);
      #1;
    end
    dout = cpu_dout;
    check({n, " stall"}, 64'(st), 64'(exp_st));
    check({n, " dout"}, {32'h0, dout}, {32'h0, exp_do});
    @(negedge clk);
    cpu_we = 1'b0; cpu_ren = 1'b0;
  endtask

  typedef struct {
    string       name;
    logic        we;
    logic [31:0] addr;
    logic [31:0] din;
    int          stall;
    logic [31:0] dout;
    int          hits;
    int          misses;
  } vec_t;

  vec_t tbl [9];

  initial begin
    tbl[0] = '{"rd5 miss",  1'b0, 32'd5,  32'h0,        11, 32'hC0DE0005, 0, 1};
    tbl[1] = '{"rd5 hit",   1'b0, 32'd5,  32'h0,         0, 32'hC0DE0005, 1, 1};
    tbl[2] = '{"wr13",      1'b1, 32'd13, 32'hDEADBEEF, 11, 32'hDEADBEEF, 1, 1};
    tbl[3] = '{"rd13 hit",  1'b0, 32'd13, 32'h0,         0, 32'hDEADBEEF, 2, 1};
    tbl[4] = '{"rd5 evict", 1'b0, 32'd5,  32'h0,        11, 32'hC0DE0005, 2, 2};
    tbl[5] = '{"rd21 miss", 1'b0, 32'd21, 32'h0,        11, 32'hC0DE0015, 2, 3};
    tbl[6] = '{"rd2 miss",  1'b0, 32'd2,  32'h0,        11, 32'hC0DE0002, 2, 4};
    tbl[7] = '{"rd2 hit",   1'b0, 32'd2,  32'h0,         0, 32'hC0DE0002, 3, 4};
    tbl[8] = '{"rd5 again", 1'b0, 32'd5,  32'h0,        11, 32'hC0DE0005, 3, 5};

    repeat (2) @(negedge clk);
    #1;
    check("rst mem_cs", {63'h0, mem_cs}, 64'h0);
    check("rst stall", {63'h0, cpu_stall}, 64'h0);
    check("rst mem_addr", {32'h0, mem_addr}, 64'h0);
    check("rst mem_din", {32'h0, mem_din}, 64'h0);
    check("rst hit_cnt", 64'(hit_cnt), 64'h0);
    check("rst miss_cnt", 64'(miss_cnt), 64'h0);
    rst = 1'b1;

    foreach (tbl[i]) begin
      req(tbl[i].name, tbl[i].we, ~tbl[i].we, tbl[i].addr, tbl[i].din, tbl[i].stall, tbl[i].dout);
      check({tbl[i].name, " hits"}, 64'(hit_cnt), 64'(tbl[i].hits));
      check({tbl[i].name, " misses"}, 64'(miss_cnt), 64'(tbl[i].misses));
      if (i == 2) check("ram13", {31'h0, wrote[13], ram[13]}, {31'h0, 1'b1, 32'hDEADBEEF});
    end

    @(negedge clk);
    cpu_we = 1'b1; cpu_ren = 1'b1; cpu_addr = 32'd6; cpu_din = 32'h12345678;
    @(negedge clk);
    #1;
    check("both mem_we", {61'h0, mem_we, mem_ren, mem_cs}, {61'h0, 3'b101});
    check("both mem_addr", {mem_din, mem_addr}, {32'h12345678, 32'd6});
    check("both stall", {63'h0, cpu_stall}, 64'h1);
    for (int k = 0; k < 100 && cpu_stall; k++) begin
      @(negedge clk);
      #1;
    end
    check("both done", {63'h0, cpu_stall}, 64'h0);
    check("both dout", {32'h0, cpu_dout}, {32'h0, 32'h12345678});
    @(negedge clk);
    cpu_we = 1'b0; cpu_ren = 1'b0;
    check("ram6", {31'h0, wrote[6], ram[6]}, {31'h0, 1'b1, 32'h12345678});
    check("both counters", {32'(hit_cnt), 32'(miss_cnt)}, {32'd3, 32'd5});
    req("rd6 hit", 1'b0, 1'b1, 32'd6, 32'h0, 0, 32'h12345678);

    @(negedge clk);
    cpu_ren = 1'b1; cpu_addr = 32'd30;
    repeat (3) @(negedge clk);
    #1;
    check("fill mem_ren", {62'h0, mem_ren, cpu_stall}, 64'h3);
    rst = 1'b0;
    #1;
    check("abort mem", {61'h0, mem_ren, mem_cs, cpu_stall}, 64'h0);
    check("abort mem_addr", {32'h0, mem_addr}, 64'h0);
    check("abort counters", {32'(hit_cnt), 32'(miss_cnt)}, 64'h0);
    @(negedge clk);
    cpu_ren = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    req("rd30 after rst", 1'b0, 1'b1, 32'd30, 32'h0, 11, 32'hC0DE001E);
    req("rd6 after rst", 1'b0, 1'b1, 32'd6, 32'h0, 11, 32'h12345678);
    check("post rst counters", {32'(hit_cnt), 32'(miss_cnt)}, {32'd0, 32'd2});

    @(negedge clk);
    cpu_ren = 1'b1; cpu_addr = 32'd6;
    repeat ((1 << CW) - 1) @(negedge clk);
    #1;
    check("hit_cnt at max", 64'(hit_cnt), 64'((1 << CW) - 1));
    repeat (4) @(negedge clk);
    #1;
    check("hit_cnt saturate", 64'(hit_cnt), 64'((1 << CW) - 1));
    check("sat no stall", {63'h0, cpu_stall}, 64'h0);
    check("sat miss_cnt", 64'(miss_cnt), 64'd2);
    cpu_ren = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
